// File: rtl/lsu_request_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between NUM_CONSUMERS
// LSU requesters; one read or write is in flight at a time.
module lsu_request_arbiter #(
    parameter int NUM_CONSUMERS = 17,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDRESS_WIDTH-1:0] consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_WIDTH-1:0]    consumer_read_data    [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDRESS_WIDTH-1:0] consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_WIDTH-1:0]    consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic                     mem_read_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,

    output logic                     mem_write_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic                     mem_write_ready,

    output logic                     busy
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELEASE
    } state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         gnt_q, gnt_d;
    logic                     is_write_q, is_write_d;

    logic                     mem_read_valid_q, mem_read_valid_d;
    logic [ADDRESS_WIDTH-1:0] mem_read_address_q, mem_read_address_d;
    logic                     mem_write_valid_q, mem_write_valid_d;
    logic [ADDRESS_WIDTH-1:0] mem_write_address_q, mem_write_address_d;
    logic [DATA_WIDTH-1:0]    mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0] consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0] consumer_write_ready_q, consumer_write_ready_d;
    logic [DATA_WIDTH-1:0]    consumer_read_data_q [NUM_CONSUMERS];
    logic [DATA_WIDTH-1:0]    consumer_read_data_d [NUM_CONSUMERS];
    logic                     busy_q, busy_d;

    logic                     win_found;
    logic [PTR_W-1:0]         win_idx;
    logic                     served_valid;

    // First requester at or after rr_ptr, wrapping around, wins the channel.
    always_comb begin : rr_scan
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CONSUMERS) begin
                idx = idx - NUM_CONSUMERS;
            end
            if (!win_found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d                = state_q;
        rr_ptr_d               = rr_ptr_q;
        gnt_d                  = gnt_q;
        is_write_d             = is_write_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_write_ready_d = consumer_write_ready_q;
        consumer_read_data_d   = consumer_read_data_q;
        served_valid           = is_write_q ? consumer_write_valid[gnt_q]
                                            : consumer_read_valid[gnt_q];

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d = win_idx;
                    // A pending read is always taken before a write from the same consumer.
                    if (consumer_read_valid[win_idx]) begin
                        is_write_d         = 1'b0;
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = consumer_read_address[win_idx];
                        state_d            = READ_WAIT;
                    end else begin
                        is_write_d          = 1'b1;
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = consumer_write_address[win_idx];
                        mem_write_data_d    = consumer_write_data[win_idx];
                        state_d             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d             = 1'b0;
                    consumer_read_ready_d[gnt_q] = 1'b1;
                    consumer_read_data_d[gnt_q]  = mem_read_data;
                    state_d                      = RELEASE;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d             = 1'b0;
                    consumer_write_ready_d[gnt_q] = 1'b1;
                    state_d                       = RELEASE;
                end
            end
            RELEASE: begin
                if (!served_valid) begin
                    if (is_write_q) begin
                        consumer_write_ready_d[gnt_q] = 1'b0;
                    end else begin
                        consumer_read_ready_d[gnt_q] = 1'b0;
                    end
                    rr_ptr_d = (gnt_q == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : gnt_q + PTR_W'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q                <= IDLE;
            rr_ptr_q               <= '0;
            gnt_q                  <= '0;
            is_write_q             <= 1'b0;
            mem_read_valid_q       <= 1'b0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= 1'b0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_write_ready_q <= '0;
            busy_q                 <= 1'b0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data_q[i] <= '0;
            end
        end else begin
            state_q                <= state_d;
            rr_ptr_q               <= rr_ptr_d;
            gnt_q                  <= gnt_d;
            is_write_q             <= is_write_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_write_ready_q <= consumer_write_ready_d;
            busy_q                 <= busy_d;
            consumer_read_data_q   <= consumer_read_data_d;
        end
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_write_ready = consumer_write_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_lsu_request_arbiter.sv
// Bench for lsu_request_arbiter: directed handshake/reset sequences, then
// randomized request rounds scored against a transaction-level round-robin model.
module tb_lsu_request_arbiter;

    localparam int N  = 17;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  consumer_read_valid;
    logic [AW-1:0] consumer_read_address [N];
    logic [N-1:0]  consumer_read_ready;
    logic [DW-1:0] consumer_read_data [N];
    logic [N-1:0]  consumer_write_valid;
    logic [AW-1:0] consumer_write_address [N];
    logic [DW-1:0] consumer_write_data [N];
    logic [N-1:0]  consumer_write_ready;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic          mem_write_valid;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_ready;
    logic          busy;

    typedef struct {
        bit            isWrite;
        int            cons;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          expQ[$];
    txn_t          respQ[$];
    txn_t          curTxn;
    int            checks = 0;
    int            errors = 0;
    bit            monOn  = 1'b0;
    int            mRr    = 0;
    int            rdCnt  = 0;
    int            wrCnt  = 0;
    bit            reqRd [N];
    bit            reqWr [N];
    logic [AW-1:0] reqRa [N];
    logic [AW-1:0] reqWa [N];
    logic [DW-1:0] reqWd [N];
    logic [N-1:0]  prevRr = '0;
    logic [N-1:0]  prevWr = '0;
    logic          prevRv = 1'b0;
    logic          prevWv = 1'b0;
    logic [N-1:0]  ohDir;
    logic [DW-1:0] acc;

    always #5 clk = ~clk;

    lsu_request_arbiter #(
        .NUM_CONSUMERS(N),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .consumer_write_valid  (consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data   (consumer_write_data),
        .consumer_write_ready  (consumer_write_ready),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data),
        .mem_write_valid       (mem_write_valid),
        .mem_write_address     (mem_write_address),
        .mem_write_data        (mem_write_data),
        .mem_write_ready       (mem_write_ready),
        .busy                  (busy)
    );

    function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: new memory requests and ready pulses pop the expected queues.
    always @(negedge clk) begin
        txn_t         t;
        logic [N-1:0] rdRise;
        logic [N-1:0] wrRise;
        logic [N-1:0] oh;
        rdRise = consumer_read_ready & ~prevRr;
        wrRise = consumer_write_ready & ~prevWr;
        if (monOn) begin
            if ((mem_read_valid && !prevRv) || (mem_write_valid && !prevWv)) begin
                if (expQ.size() == 0) begin
                    checkOutput("req_unexpected", 64'(expQ.size()), 64'(1));
                end else begin
                    t = expQ.pop_front();
                    checkOutput("req_kind", 64'({mem_read_valid, mem_write_valid}),
                                64'(t.isWrite ? 2'b01 : 2'b10));
                    checkOutput("req_addr", 64'(t.isWrite ? mem_write_address : mem_read_address),
                                64'(t.addr));
                    if (t.isWrite) begin
                        checkOutput("req_wdata", 64'(mem_write_data), 64'(t.wdata));
                    end
                    curTxn = t;
                    respQ.push_back(t);
                end
            end else if (mem_read_valid) begin
                checkOutput("rd_hold", 64'({mem_write_valid, mem_read_address}), 64'({1'b0, curTxn.addr}));
            end else if (mem_write_valid) begin
                checkOutput("wr_hold", 64'({mem_write_address, mem_write_data}),
                            64'({curTxn.addr, curTxn.wdata}));
            end
            if ((rdRise | wrRise) != '0) begin
                if (respQ.size() == 0) begin
                    checkOutput("rdy_unexpected", 64'(respQ.size()), 64'(1));
                end else begin
                    t = respQ.pop_front();
                    oh = '0;
                    oh[t.cons] = 1'b1;
                    checkOutput("rdy_read", 64'(rdRise), 64'(t.isWrite ? {N{1'b0}} : oh));
                    checkOutput("rdy_write", 64'(wrRise), 64'(t.isWrite ? oh : {N{1'b0}}));
                    if (!t.isWrite) begin
                        checkOutput("rdy_rdata", 64'(consumer_read_data[t.cons]), 64'(t.rdata));
                    end
                    checkOutput("rdy_onehot", 64'($countones({consumer_read_ready, consumer_write_ready})), 64'(1));
                end
            end
        end
        prevRr <= consumer_read_ready;
        prevWr <= consumer_write_ready;
        prevRv <= mem_read_valid;
        prevWv <= mem_write_valid;
    end

    task automatic clearReq();
        for (int i = 0; i < N; i++) begin
            reqRd[i] = 1'b0;
            reqWr[i] = 1'b0;
            reqRa[i] = '0;
            reqWa[i] = '0;
            reqWd[i] = '0;
        end
    endtask

    task automatic randomReq();
        for (int i = 0; i < N; i++) begin
            reqRd[i] = ($urandom_range(0, 2) == 0);
            reqWr[i] = ($urandom_range(0, 2) == 0);
            reqRa[i] = AW'($urandom);
            reqWa[i] = AW'($urandom);
            reqWd[i] = DW'($urandom);
        end
    endtask

    // One cycle of memory responder and consumer behaviour, driven at the falling edge.
    task automatic serviceCycle();
        if (mem_read_valid && !mem_read_ready) begin
            if (rdCnt == 0) begin
                mem_read_ready = 1'b1;
                mem_read_data  = memFn(mem_read_address);
            end else begin
                rdCnt--;
            end
        end else begin
            mem_read_ready = !mem_read_valid && ($urandom_range(0, 5) == 0);
            mem_read_data  = DW'($urandom);
            rdCnt          = int'($urandom_range(0, 3));
        end
        if (mem_write_valid && !mem_write_ready) begin
            if (wrCnt == 0) begin
                mem_write_ready = 1'b1;
            end else begin
                wrCnt--;
            end
        end else begin
            mem_write_ready = !mem_write_valid && ($urandom_range(0, 5) == 0);
            wrCnt           = int'($urandom_range(0, 3));
        end
        for (int i = 0; i < N; i++) begin
            if (consumer_read_ready[i] && consumer_read_valid[i] && $urandom_range(0, 2) == 0) begin
                consumer_read_valid[i] = 1'b0;
            end
            if (consumer_write_ready[i] && consumer_write_valid[i] && $urandom_range(0, 2) == 0) begin
                consumer_write_valid[i] = 1'b0;
            end
        end
        if (mem_read_valid && !curTxn.isWrite && $urandom_range(0, 9) == 0) begin
            consumer_read_valid[curTxn.cons] = 1'b0;
        end
        if (mem_write_valid && curTxn.isWrite && $urandom_range(0, 9) == 0) begin
            consumer_write_valid[curTxn.cons] = 1'b0;
        end
    endtask

    // Predict the full serve order for the request set, then drive it until drained.
    task automatic applyStimulus(input int maxCycles);
        bit   pRd [N];
        bit   pWr [N];
        int   ptr;
        int   win;
        txn_t t;
        bit   done;
        pRd = reqRd;
        pWr = reqWr;
        ptr = mRr;
        for (int n = 0; n < 2 * N; n++) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && (pRd[(ptr + k) % N] || pWr[(ptr + k) % N])) begin
                    win = (ptr + k) % N;
                end
            end
            if (win < 0) break;
            t.cons    = win;
            t.isWrite = !pRd[win];
            if (pRd[win]) begin
                t.addr   = reqRa[win];
                t.wdata  = '0;
                t.rdata  = memFn(reqRa[win]);
                pRd[win] = 1'b0;
            end else begin
                t.addr   = reqWa[win];
                t.wdata  = reqWd[win];
                t.rdata  = '0;
                pWr[win] = 1'b0;
            end
            expQ.push_back(t);
            ptr = (win + 1) % N;
        end
        mRr = ptr;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            consumer_read_valid[i]    = reqRd[i];
            consumer_read_address[i]  = reqRa[i];
            consumer_write_valid[i]   = reqWr[i];
            consumer_write_address[i] = reqWa[i];
            consumer_write_data[i]    = reqWd[i];
        end
        done = 1'b0;
        for (int cyc = 0; cyc < maxCycles && !done; cyc++) begin
            @(negedge clk);
            serviceCycle();
            done = (consumer_read_valid == '0) && (consumer_write_valid == '0) && !busy
                   && (expQ.size() == 0) && (respQ.size() == 0);
        end
        checkOutput("round_done", 64'(done), 64'(1));
        expQ.delete();
        respQ.delete();
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
    endtask

    initial begin
        reset           = 1'b0;
        mem_read_ready  = 1'b1;
        mem_write_ready = 1'b1;
        mem_read_data   = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) begin
            consumer_read_valid[i]    = 1'b1;
            consumer_write_valid[i]   = 1'b1;
            consumer_read_address[i]  = AW'($urandom);
            consumer_write_address[i] = AW'($urandom);
            consumer_write_data[i]    = DW'($urandom);
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_valid", 64'({mem_read_valid, mem_write_valid}), 64'(0));
        checkOutput("rst_mem_bus", 64'({mem_read_address, mem_write_address}), 64'(0));
        checkOutput("rst_mem_wdata", 64'(mem_write_data), 64'(0));
        checkOutput("rst_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        acc = '0;
        for (int i = 0; i < N; i++) acc = acc | consumer_read_data[i];
        checkOutput("rst_rdata", 64'(acc), 64'(0));

        consumer_read_valid      = '0;
        consumer_write_valid     = '0;
        mem_read_ready           = 1'b0;
        mem_write_ready          = 1'b0;
        consumer_read_address[3] = 16'h0040;
        consumer_read_valid[3]   = 1'b1;
        reset                    = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_exit_req", 64'({mem_read_valid, mem_read_address}), 64'({1'b1, 16'h0040}));
        @(posedge clk); #1;
        checkOutput("rd_wait_hold", 64'({mem_read_valid, consumer_read_ready}), 64'({1'b1, {N{1'b0}}}));
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ohDir = '0;
        ohDir[3] = 1'b1;
        checkOutput("rd_ready3", 64'(consumer_read_ready), 64'(ohDir));
        checkOutput("rd_data3", 64'(consumer_read_data[3]), 64'(32'hDEAD_BEEF));
        checkOutput("rd_mem_drop", 64'(mem_read_valid), 64'(0));
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("rd_ready_hold", 64'(consumer_read_ready), 64'(ohDir));
        end
        @(negedge clk);
        consumer_read_valid[3] = 1'b0;
        @(posedge clk); #1;
        checkOutput("rd_ready_clear", 64'({consumer_read_ready, busy}), 64'(0));
        checkOutput("rd_data_keep", 64'(consumer_read_data[3]), 64'(32'hDEAD_BEEF));

        @(negedge clk);
        consumer_write_address[7] = 16'h1234;
        consumer_write_data[7]    = 32'hCAFE_F00D;
        consumer_write_valid[7]   = 1'b1;
        @(posedge clk); #1;
        checkOutput("wr_issue", 64'({mem_write_valid, mem_write_address, mem_write_data}),
                    64'({1'b1, 16'h1234, 32'hCAFE_F00D}));
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("wr_stall_hold", 64'({mem_write_valid, mem_write_address, mem_write_data}),
                        64'({1'b1, 16'h1234, 32'hCAFE_F00D}));
        end
        @(negedge clk);
        mem_write_ready = 1'b1;
        @(posedge clk); #1;
        ohDir = '0;
        ohDir[7] = 1'b1;
        checkOutput("wr_ready7", 64'(consumer_write_ready), 64'(ohDir));
        checkOutput("wr_mem_drop", 64'(mem_write_valid), 64'(0));
        @(negedge clk);
        mem_write_ready         = 1'b0;
        consumer_write_valid[7] = 1'b0;
        @(posedge clk); #1;
        checkOutput("wr_ready_clear", 64'(consumer_write_ready), 64'(0));

        @(negedge clk);
        consumer_read_address[9] = 16'h0099;
        consumer_read_valid[9]   = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_issue", 64'({mem_read_valid, mem_read_address}), 64'({1'b1, 16'h0099}));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_drop", 64'({mem_read_valid, busy}), 64'(0));
        consumer_read_valid[9] = 1'b0;
        @(negedge clk);
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 32'h1234_5678;
        @(posedge clk); #1;
        checkOutput("late_ready", 64'({consumer_read_ready, mem_read_valid, busy}), 64'(0));
        @(negedge clk);
        mem_read_ready = 1'b0;
        mRr            = 0;

        monOn = 1'b1;
        clearReq();
        reqRd[0]  = 1'b1; reqRa[0]  = 16'h0100;
        reqRd[5]  = 1'b1; reqRa[5]  = 16'h0500;
        reqRd[16] = 1'b1; reqRa[16] = 16'h1600;
        applyStimulus(2000);
        clearReq();
        reqRd[5] = 1'b1; reqRa[5] = 16'h0501;
        reqRd[0] = 1'b1; reqRa[0] = 16'h0101;
        applyStimulus(2000);
        clearReq();
        reqRd[2] = 1'b1; reqRa[2] = 16'h0010;
        reqWr[2] = 1'b1; reqWa[2] = 16'h0020; reqWd[2] = 32'h0000_0055;
        applyStimulus(2000);
        for (int r = 0; r < 40; r++) begin
            randomReq();
            applyStimulus(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
